// File: rtl/sid_write_scheduler.sv
// Pops write/delay entries from the host FIFO and replays them into the SID core,
// pacing register writes and delays on the SID tick; one write per tick at most.
module sid_write_scheduler #(
  parameter int FILL_BITS  = 8,
  parameter int STALL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  clear_stats,
  input  logic [FILL_BITS-1:0]  fifo_fill,
  output logic                  fifo_rd_en,
  input  logic [15:0]           fifo_rd_data,
  output logic                  sid_we,
  output logic [4:0]            sid_addr,
  output logic [7:0]            sid_data,
  output logic                  busy,
  output logic [STALL_BITS-1:0] stall_cnt
);

  typedef enum logic [2:0] {IDLE, POP, DECODE, WRITE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [14:0] delay_cnt;

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE:   if (run && fifo_fill != '0) state_nxt = POP;
      POP: begin
        fifo_rd_en = 1'b1;
        state_nxt  = DECODE;
      end
      DECODE: begin
        if (!fifo_rd_data[15])               state_nxt = WRITE;
        else if (fifo_rd_data[14:0] == 15'd0) state_nxt = IDLE;
        else                                  state_nxt = WAIT;
      end
      WRITE:  if (tick) state_nxt = IDLE;
      // A zero count cannot normally reach WAIT; leave rather than hang.
      WAIT: begin
        if (delay_cnt == 15'd0)                state_nxt = IDLE;
        else if (tick && delay_cnt == 15'd1)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sid_we    <= 1'b0;
      sid_addr  <= 5'd0;
      sid_data  <= 8'd0;
      delay_cnt <= 15'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sid_we <= (state == WRITE) && tick;

      if (state == DECODE) begin
        if (!fifo_rd_data[15]) begin
          sid_addr <= fifo_rd_data[12:8];
          sid_data <= fifo_rd_data[7:0];
        end else begin
          delay_cnt <= fifo_rd_data[14:0];
        end
      end else if (state == WAIT && tick && delay_cnt != 15'd0) begin
        delay_cnt <= delay_cnt - 15'd1;
      end

      // Starvation ticks: host is not keeping the FIFO fed while running.
      if (clear_stats)
        stall_cnt <= '0;
      else if (tick && state == IDLE && run && fifo_fill == '0 && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_BITS'(1);
    end
  end

endmodule

// File: tb/tb_sid_write_scheduler.sv
// Directed bench for sid_write_scheduler with a behavioural FIFO model
// and a per-entry vector table plus hand sequences for multi-cycle cases.
module tb_sid_write_scheduler;

  logic        clk = 1'b0;
  logic        reset, tick, run, clear_stats;
  logic [7:0]  fifo_fill;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        sid_we;
  logic [4:0]  sid_addr;
  logic [7:0]  sid_data;
  logic        busy;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  sid_write_scheduler #(.FILL_BITS(8), .STALL_BITS(16)) dut (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .clear_stats(clear_stats),
    .fifo_fill(fifo_fill), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [15:0] entry;
    int          we;
    logic [4:0]  addr;
    logic [7:0]  data;
    int          busy_cyc;
  } vec_t;

  vec_t          vecs[7];
  logic [15:0]   q[$];
  logic [12:0]   we_log[$];
  int tests = 0, fails = 0;
  int rd_cnt = 0, rd_adj = 0, rd_empty = 0, we_cnt = 0, busy_cnt = 0;
  logic prev_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    q.push_back(w);
    fifo_fill = fifo_fill + 8'd1;
  endtask

  // Observe on the falling edge, then model the FIFO read just after the rising edge.
  task automatic cyc();
    logic pop;
    @(negedge clk);
    if (fifo_rd_en) begin
      rd_cnt++;
      if (prev_rd) rd_adj++;
      if (fifo_fill == 8'd0) rd_empty++;
    end
    prev_rd = fifo_rd_en;
    if (sid_we) begin
      we_cnt++;
      we_log.push_back({sid_addr, sid_data});
    end
    if (busy) busy_cnt++;
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) begin
      fifo_rd_data = q.pop_front();
      fifo_fill    = fifo_fill - 8'd1;
    end
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int b0, w0, r0;
    vecs[0] = '{16'h0418, 1, 5'h04, 8'h18, 3};
    vecs[1] = '{16'h8000, 0, 5'h04, 8'h18, 2};
    vecs[2] = '{16'h7FAA, 1, 5'h1F, 8'hAA, 3};
    vecs[3] = '{16'h8003, 0, 5'h1F, 8'hAA, 5};
    vecs[4] = '{16'h0000, 1, 5'h00, 8'h00, 3};
    vecs[5] = '{16'h8001, 0, 5'h00, 8'h00, 3};
    vecs[6] = '{16'h1805, 1, 5'h18, 8'h05, 3};

    reset = 1'b1; tick = 1'b0; run = 1'b0; clear_stats = 1'b0;
    fifo_fill = 8'd0; fifo_rd_data = 16'd0;
    cycn(2);
    reset = 1'b0;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_we", sid_we, 0);
    chk("rst_addr", sid_addr, 0);
    chk("rst_data", sid_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_cnt, 0);

    // Starved run: 10 ticks idle with empty FIFO
    run = 1'b1; tick = 1'b1;
    cycn(10);
    tick = 1'b0;
    chk("stall_10", stall_cnt, 10);
    chk("stall_no_pop", rd_cnt, 0);
    chk("stall_not_busy", busy_cnt, 0);
    clear_stats = 1'b1; tick = 1'b1;
    cyc();
    clear_stats = 1'b0; tick = 1'b0;
    chk("stall_clear", stall_cnt, 0);

    // Single-entry vectors, tick every cycle
    tick = 1'b1;
    for (int v = 0; v < 7; v++) begin
      b0 = busy_cnt; w0 = we_cnt;
      push(vecs[v].entry);
      cycn(12);
      chk($sformatf("vec%0d_we", v), we_cnt - w0, vecs[v].we);
      chk($sformatf("vec%0d_busy", v), busy_cnt - b0, vecs[v].busy_cyc);
      chk($sformatf("vec%0d_addr", v), sid_addr, vecs[v].addr);
      chk($sformatf("vec%0d_data", v), sid_data, vecs[v].data);
    end

    // Delay 3 then write, with sparse ticks
    tick = 1'b0; r0 = rd_cnt; w0 = we_cnt;
    push(16'h8003); push(16'h1805);
    cycn(6);
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    chk("dly_still_wait_pops", rd_cnt - r0, 1);
    chk("dly_still_wait_busy", busy, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    cycn(6);
    chk("dly_write_no_we", we_cnt - w0, 0);
    chk("dly_write_pops", rd_cnt - r0, 2);
    chk("dly_write_busy", busy, 1);
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    chk("dly_write_we", we_cnt - w0, 1);
    chk("dly_write_addr", sid_addr, 5'h18);
    chk("dly_write_data", sid_data, 8'h05);
    chk("dly_write_idle", busy, 0);

    // Burst of 4 writes
    tick = 1'b1; r0 = rd_cnt; w0 = we_cnt;
    we_log.delete();
    push(16'h0111); push(16'h0222); push(16'h0333); push(16'h1F44);
    cycn(24);
    chk("burst_we", we_cnt - w0, 4);
    chk("burst_pops", rd_cnt - r0, 4);
    chk("burst_fill", fifo_fill, 0);
    if (we_log.size() == 4) begin
      chk("burst_0", we_log[0], {5'h01, 8'h11});
      chk("burst_1", we_log[1], {5'h02, 8'h22});
      chk("burst_2", we_log[2], {5'h03, 8'h33});
      chk("burst_3", we_log[3], {5'h1F, 8'h44});
    end

    // Drop run during a delay of 5
    r0 = rd_cnt; w0 = we_cnt;
    push(16'h8005); push(16'h0233);
    cycn(3);
    run = 1'b0;
    cycn(10);
    chk("halt_idle", busy, 0);
    chk("halt_fill", fifo_fill, 1);
    chk("halt_pops", rd_cnt - r0, 1);
    chk("halt_we", we_cnt - w0, 0);
    run = 1'b1;
    cycn(8);
    chk("resume_we", we_cnt - w0, 1);
    chk("resume_addr", sid_addr, 5'h02);
    chk("resume_data", sid_data, 8'h33);
    chk("resume_fill", fifo_fill, 0);

    // Reset while WRITE waits for a tick
    tick = 1'b0; r0 = rd_cnt; w0 = we_cnt;
    push(16'h0A55);
    cycn(5);
    chk("rw_busy", busy, 1);
    reset = 1'b1; tick = 1'b1;
    cyc();
    reset = 1'b0; tick = 1'b0;
    chk("rw_we", sid_we, 0);
    chk("rw_addr", sid_addr, 0);
    chk("rw_data", sid_data, 0);
    chk("rw_busy_after", busy, 0);
    chk("rw_stall", stall_cnt, 0);
    chk("rw_rd_en", fifo_rd_en, 0);
    tick = 1'b1;
    cycn(4);
    chk("rw_lost_we", we_cnt - w0, 0);
    chk("rw_lost_pops", rd_cnt - r0, 1);
    chk("rw_lost_fill", fifo_fill, 0);

    chk("never_adjacent_pops", rd_adj, 0);
    chk("never_pop_empty", rd_empty, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
